// File: rtl/sm4_mode_engine.sv
// ---------------------------------------------------------------------------
// sm4_mode_engine
//
// Block-cipher mode wrapper around an external SM4 core. Input blocks are
// buffered in a small FIFO, combined with the chaining value according to the
// latched mode (ECB, CBC, CTR), handed to the core through a req/ack
// handshake, and the post-processed result is presented on a valid/ready
// output port. One block is in flight at a time.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_mode_i            0 ECB, 1 CBC, 2 CTR, 3 reserved (latched by iv_load_i)
//   cfg_dec_i             1 = decrypt (latched by iv_load_i)
//   iv_i, iv_load_i       IV / initial counter and its load pulse
//   clear_i               flush FIFO and abort the current block
//   in_valid_i/in_ready_o, in_data_i     input block stream
//   out_valid_o/out_ready_i, out_data_o  output block stream
//   core_req_o/core_ack_i, core_dec_o,
//   core_data_o/core_data_i              SM4 core operand/result handshake
//   busy_o                FSM not idle or FIFO non-empty
//   err_o                 sticky: reserved mode latched or illegal IV load
//   fifo_level_o          FIFO occupancy
// ---------------------------------------------------------------------------
module sm4_mode_engine #(
   parameter int BLK_W      = 128,
   parameter int FIFO_DEPTH = 4,
   parameter int CTR_W      = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [1:0]                  cfg_mode_i,
   input  logic                        cfg_dec_i,
   input  logic [BLK_W-1:0]            iv_i,
   input  logic                        iv_load_i,
   input  logic                        clear_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [BLK_W-1:0]            in_data_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [BLK_W-1:0]            out_data_o,
   output logic                        core_req_o,
   input  logic                        core_ack_i,
   output logic                        core_dec_o,
   output logic [BLK_W-1:0]            core_data_o,
   input  logic [BLK_W-1:0]            core_data_i,
   output logic                        busy_o,
   output logic                        err_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   // Selects the counter field of the chaining value in CTR mode.
   localparam logic [BLK_W-1:0] CTR_MASK = {BLK_W{1'b1}} >> (BLK_W - CTR_W);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DRAIN} state_t;
   typedef enum logic [1:0] {MODE_ECB = 2'd0, MODE_CBC = 2'd1,
                             MODE_CTR = 2'd2, MODE_RSVD = 2'd3} mode_t;

   state_t            state_q;
   mode_t             mode_q;
   logic              dec_q;
   logic [BLK_W-1:0]  chain_q;
   logic [BLK_W-1:0]  work_q;

   logic [BLK_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [LVL_W-1:0]  count_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              load_ok;
   logic [BLK_W-1:0]  head;
   logic [BLK_W-1:0]  issue_data;
   logic              issue_dec;
   logic [BLK_W-1:0]  result_data;
   logic [BLK_W-1:0]  chain_next;

   assign fifo_full    = (count_q == LVL_W'(FIFO_DEPTH));
   assign fifo_empty   = (count_q == '0);
   assign head         = fifo_mem[rd_ptr_q];
   assign fifo_level_o = count_q;
   assign busy_o       = (state_q != IDLE) || !fifo_empty;
   assign in_ready_o   = !fifo_full && (mode_q != MODE_RSVD) && (state_q != DRAIN);

   // clear_i wins over a same-cycle push: that beat is flushed with the rest.
   assign push    = in_valid_i && in_ready_o && !clear_i;
   assign pop     = (state_q == IDLE) && !fifo_empty && (mode_q != MODE_RSVD) && !clear_i;
   assign load_ok = (state_q == IDLE) && fifo_empty;

   // Operand presented to the core for the block at the FIFO head.
   // NOTE: every variable assigned in always_comb gets a default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      issue_data = head;
      issue_dec  = dec_q;
      case (mode_q)
         MODE_CBC: if (!dec_q) issue_data = head ^ chain_q;
         MODE_CTR: begin
            issue_data = chain_q;
            issue_dec  = 1'b0;
         end
         default: ;
      endcase
   end

   // Post-processing of the core result and the next chaining value.
   always_comb begin
      result_data = core_data_i;
      chain_next  = chain_q;
      case (mode_q)
         MODE_CBC: begin
            if (dec_q) begin
               result_data = core_data_i ^ chain_q;
               chain_next  = work_q;
            end else begin
               chain_next  = core_data_i;
            end
         end
         MODE_CTR: begin
            result_data = core_data_i ^ work_q;
            // Only the counter field wraps; the nonce bits above it are kept.
            chain_next  = (chain_q & ~CTR_MASK) | ((chain_q + BLK_W'(1)) & CTR_MASK);
         end
         default: ;
      endcase
   end

   // NOTE: the FIFO storage has no reset; occupancy is tracked by the
   // pointers and count, so stale contents are never observed.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= in_data_i;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + LVL_W'(1);
            2'b01:   count_q <= count_q - LVL_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mode_q      <= MODE_ECB;
         dec_q       <= 1'b0;
         chain_q     <= '0;
         work_q      <= '0;
         err_o       <= 1'b0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         core_req_o  <= 1'b0;
         core_dec_o  <= 1'b0;
         core_data_o <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  work_q      <= head;
                  core_data_o <= issue_data;
                  core_dec_o  <= issue_dec;
                  core_req_o  <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            // The request is already on the bus in ISSUE, so an abort there
            // must also complete the handshake before returning to IDLE.
            ISSUE, WAIT: begin
               if (clear_i) begin
                  if (core_ack_i) begin
                     core_req_o <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     state_q    <= DRAIN;
                  end
               end else if (core_ack_i) begin
                  core_req_o  <= 1'b0;
                  out_data_o  <= result_data;
                  out_valid_o <= 1'b1;
                  chain_q     <= chain_next;
                  state_q     <= EMIT;
               end else begin
                  state_q <= WAIT;
               end
            end
            EMIT: begin
               if (clear_i || out_ready_i) begin
                  out_valid_o <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            DRAIN: begin
               if (core_ack_i) begin
                  core_req_o <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Configuration may only change between streams; a load anywhere
         // else is dropped and flagged.
         if (iv_load_i) begin
            if (load_ok) begin
               mode_q  <= mode_t'(cfg_mode_i);
               dec_q   <= cfg_dec_i;
               chain_q <= iv_i;
               err_o   <= (cfg_mode_i == MODE_RSVD);
            end else begin
               err_o   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sm4_mode_engine.sv
// ---------------------------------------------------------------------------
// tb_sm4_mode_engine
//
// Self-checking bench for sm4_mode_engine. A stub core acks three cycles
// after a request and returns the bitwise inverse of its operand. Expected
// outputs come from a stream-level model of ECB/CBC/CTR chaining.
// ---------------------------------------------------------------------------
module tb_sm4_mode_engine;

   localparam int BLK_W      = 128;
   localparam int FIFO_DEPTH = 4;
   localparam int CTR_W      = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         cfg_mode;
   logic               cfg_dec;
   logic [BLK_W-1:0]   iv;
   logic               iv_load;
   logic               clear;
   logic               in_valid;
   logic               in_ready;
   logic [BLK_W-1:0]   in_data;
   logic               out_valid;
   logic               out_ready;
   logic [BLK_W-1:0]   out_data;
   logic               core_req;
   logic               core_ack = 1'b0;
   logic               core_dec;
   logic [BLK_W-1:0]   core_operand;
   logic [BLK_W-1:0]   core_result;
   logic               busy;
   logic               err;
   logic [2:0]         fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   logic [BLK_W-1:0] blk_q[$];
   logic [BLK_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   sm4_mode_engine #(.BLK_W(BLK_W), .FIFO_DEPTH(FIFO_DEPTH), .CTR_W(CTR_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cfg_mode_i   (cfg_mode),
      .cfg_dec_i    (cfg_dec),
      .iv_i         (iv),
      .iv_load_i    (iv_load),
      .clear_i      (clear),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .core_req_o   (core_req),
      .core_ack_i   (core_ack),
      .core_dec_o   (core_dec),
      .core_data_o  (core_operand),
      .core_data_i  (core_result),
      .busy_o       (busy),
      .err_o        (err),
      .fifo_level_o (fifo_level)
   );

   // Stub SM4 core: result is the inverse of the operand, ack 3 cycles on.
   int ack_cnt = 0;
   assign core_result = ~core_operand;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         core_ack = 1'b0;
         ack_cnt  = 0;
      end else if (core_ack) begin
         core_ack = 1'b0;
         ack_cnt  = 0;
      end else if (core_req) begin
         ack_cnt++;
         if (ack_cnt == 3) core_ack = 1'b1;
      end else begin
         ack_cnt = 0;
      end
   end

   function automatic logic [BLK_W-1:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Expected output stream for blk_q under the given mode, using the
   // inverse-of-operand behaviour of the stub core.
   task automatic model_expected(input int mode, input bit dec, input logic [BLK_W-1:0] iv_v);
      logic [BLK_W-1:0] chain;
      logic [BLK_W-1:0] out_v;
      chain = iv_v;
      exp_q.delete();
      foreach (blk_q[i]) begin
         case (mode)
            0: out_v = ~blk_q[i];
            1: begin
               if (!dec) begin
                  out_v = ~(blk_q[i] ^ chain);
                  chain = out_v;
               end else begin
                  out_v = ~blk_q[i] ^ chain;
                  chain = blk_q[i];
               end
            end
            default: begin
               out_v = ~chain ^ blk_q[i];
               chain[CTR_W-1:0] = chain[CTR_W-1:0] + 1;
            end
         endcase
         exp_q.push_back(out_v);
      end
   endtask

   task automatic idle_inputs();
      cfg_mode  = 2'd0;
      cfg_dec   = 1'b0;
      iv        = '0;
      iv_load   = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
   endtask

   task automatic load_cfg(input logic [1:0] m, input bit d, input logic [BLK_W-1:0] v);
      @(negedge clk);
      cfg_mode = m;
      cfg_dec  = d;
      iv       = v;
      iv_load  = 1'b1;
      @(negedge clk);
      iv_load  = 1'b0;
   endtask

   task automatic push_one(input logic [BLK_W-1:0] d, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop_one(output logic [BLK_W-1:0] d, output bit ok);
      ok = 1'b0;
      d  = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         if (out_valid) begin
            d  = out_data;
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (!busy && !out_valid) begin
            idle = 1'b1;
            break;
         end
      end
      n_checks++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL wait_idle: busy=%b out_valid=%b, required idle", busy, out_valid); end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (core_req !== 1'b0)   begin n_fail++; $display("FAIL reset_core_req: got %b want 0", core_req); end
      n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (out_data !== '0)     begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++; if (core_operand !== '0) begin n_fail++; $display("FAIL reset_core_data: got %h want 0", core_operand); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_ecb_latency();
      localparam logic [BLK_W-1:0] EXP = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
      bit seen = 1'b0;
      load_cfg(2'd0, 1'b0, '0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 128'h1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ecb_accept: in_ready=%b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++; if (core_req !== 1'b0)   begin n_fail++; $display("FAIL lat_req_t1: got %b want 0", core_req); end
      n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL lat_level_t1: got %0d want 1", fifo_level); end
      @(negedge clk);
      #1;
      n_checks++; if (core_req !== 1'b1)      begin n_fail++; $display("FAIL lat_req_t2: got %b want 1", core_req); end
      n_checks++; if (core_operand !== 128'h1) begin n_fail++; $display("FAIL ecb_operand: got %h want 1", core_operand); end
      n_checks++; if (fifo_level !== 3'd0)    begin n_fail++; $display("FAIL lat_level_t2: got %0d want 0", fifo_level); end
      for (int i = 0; i < 10; i++) begin
         if (core_ack) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      n_checks++; if (seen !== 1'b1)      begin n_fail++; $display("FAIL ecb_ack_timeout: ack seen=%b want 1", seen); end
      n_checks++; if (core_req !== 1'b1)  begin n_fail++; $display("FAIL ecb_req_at_ack: got %b want 1", core_req); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ecb_valid_at_ack: got %b want 0", out_valid); end
      @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ecb_valid_after_ack: got %b want 1", out_valid); end
      n_checks++; if (out_data !== EXP)   begin n_fail++; $display("FAIL ecb_data: got %h want %h", out_data, EXP); end
      n_checks++; if (core_req !== 1'b0)  begin n_fail++; $display("FAIL ecb_req_drop: got %b want 0", core_req); end
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== EXP) begin n_fail++; $display("FAIL ecb_emit_hold: valid=%b data=%h want 1/%h", out_valid, out_data, EXP); end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ecb_valid_release: got %b want 0", out_valid); end
   endtask

   task automatic test_cbc_enc();
      logic [BLK_W-1:0] d;
      bit ok;
      wait_idle();
      load_cfg(2'd1, 1'b0, 128'h0F);
      push_one(128'hF0, ok);
      push_one(128'h00, ok);
      pop_one(d, ok);
      n_checks++; if (!ok || d !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00) begin n_fail++; $display("FAIL cbc_enc_0: got %h ok=%b want ff..ff00", d, ok); end
      pop_one(d, ok);
      n_checks++; if (!ok || d !== 128'h0000_0000_0000_0000_0000_0000_0000_00FF) begin n_fail++; $display("FAIL cbc_enc_1: got %h ok=%b want 00..00ff", d, ok); end
   endtask

   task automatic test_ctr_wrap();
      logic [BLK_W-1:0] d;
      bit ok;
      wait_idle();
      load_cfg(2'd2, 1'b1, {96'h0, 32'hFFFF_FFFF});
      push_one('0, ok);
      push_one('0, ok);
      pop_one(d, ok);
      n_checks++; if (!ok || d !== {{96{1'b1}}, 32'h0}) begin n_fail++; $display("FAIL ctr_0: got %h ok=%b want ff..ff_00000000", d, ok); end
      pop_one(d, ok);
      n_checks++; if (!ok || d !== {128{1'b1}}) begin n_fail++; $display("FAIL ctr_1: got %h ok=%b want all ones", d, ok); end
   endtask

   task automatic test_backpressure();
      logic [BLK_W-1:0] d;
      bit ok;
      int idx = 0;
      wait_idle();
      load_cfg(2'd0, 1'b0, '0);
      blk_q.delete();
      for (int k = 0; k < 6; k++) blk_q.push_back(rand_blk());
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (idx < 6) begin
            in_valid = 1'b1;
            in_data  = blk_q[idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) idx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++; if (idx != 5)            begin n_fail++; $display("FAIL bp_accepted: got %0d want 5", idx); end
      n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
      n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_held_valid: got %b want 1", out_valid); end
      for (int k = 0; k < 5; k++) begin
         pop_one(d, ok);
         n_checks++; if (!ok || d !== ~blk_q[k]) begin n_fail++; $display("FAIL bp_out_%0d: got %h ok=%b want %h", k, d, ok, ~blk_q[k]); end
      end
      wait_idle();
      n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL bp_final_level: got %0d want 0", fifo_level); end
   endtask

   task automatic test_clear_in_wait();
      logic [BLK_W-1:0] iv_r;
      logic [BLK_W-1:0] x;
      logic [BLK_W-1:0] d;
      bit ok;
      bit saw_ack   = 1'b0;
      bit bad_valid = 1'b0;
      int idx = 0;
      wait_idle();
      iv_r = rand_blk();
      load_cfg(2'd1, 1'b0, iv_r);
      blk_q.delete();
      for (int k = 0; k < 3; k++) blk_q.push_back(rand_blk());
      for (int c = 0; c < 10 && idx < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = blk_q[idx];
         #1;
         if (in_ready) idx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++; if (core_req !== 1'b1 || fifo_level !== 3'd2 || core_ack !== 1'b0) begin n_fail++; $display("FAIL clear_pre: req=%b level=%0d ack=%b want 1/2/0", core_req, fifo_level, core_ack); end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL clear_level: got %0d want 0", fifo_level); end
      n_checks++; if (core_req !== 1'b1)   begin n_fail++; $display("FAIL clear_req_held: got %b want 1", core_req); end
      n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL clear_drain_ready: got %b want 0", in_ready); end
      for (int i = 0; i < 10; i++) begin
         if (out_valid) bad_valid = 1'b1;
         if (core_ack && core_req) saw_ack = 1'b1;
         if (!core_req) break;
         @(negedge clk);
         #1;
      end
      n_checks++; if (saw_ack !== 1'b1)  begin n_fail++; $display("FAIL clear_req_until_ack: saw_ack=%b want 1", saw_ack); end
      n_checks++; if (core_req !== 1'b0) begin n_fail++; $display("FAIL clear_req_drop: got %b want 0", core_req); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) bad_valid = 1'b1;
      end
      n_checks++; if (bad_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_output: out_valid seen=%b want 0", bad_valid); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL clear_idle: busy=%b want 0", busy); end
      x = rand_blk();
      push_one(x, ok);
      pop_one(d, ok);
      n_checks++; if (!ok || d !== ~(x ^ iv_r)) begin n_fail++; $display("FAIL clear_chain_kept: got %h ok=%b want %h", d, ok, ~(x ^ iv_r)); end
   endtask

   task automatic test_err();
      logic [BLK_W-1:0] x;
      logic [BLK_W-1:0] d;
      bit ok;
      int acc = 0;
      wait_idle();
      load_cfg(2'd0, 1'b0, '0);
      #1;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b want 0", err); end
      x = rand_blk();
      push_one(x, ok);
      cfg_mode = 2'd2;
      iv       = rand_blk();
      iv_load  = 1'b1;
      @(negedge clk);
      iv_load  = 1'b0;
      #1;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_illegal_load: got %b want 1", err); end
      pop_one(d, ok);
      n_checks++; if (!ok || d !== ~x) begin n_fail++; $display("FAIL err_load_ignored: got %h ok=%b want %h", d, ok, ~x); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
      wait_idle();
      load_cfg(2'd3, 1'b0, '0);
      #1;
      n_checks++; if (err !== 1'b1)      begin n_fail++; $display("FAIL err_rsvd_mode: got %b want 1", err); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL err_rsvd_ready: got %b want 0", in_ready); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = rand_blk();
         #1;
         if (in_ready) acc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++; if (acc != 0 || fifo_level !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_rsvd_blocked: acc=%0d level=%0d busy=%b want 0/0/0", acc, fifo_level, busy); end
      load_cfg(2'd0, 1'b0, '0);
      #1;
      n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL err_cleared: got %b want 0", err); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready_back: got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit bad = 1'b0;
      wait_idle();
      load_cfg(2'd0, 1'b0, '0);
      push_one(rand_blk(), ok);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (core_req !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_abort: req=%b valid=%b want 0/0", core_req, out_valid); end
      n_checks++; if (busy !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state: busy=%b level=%0d ready=%b want 0/0/1", busy, fifo_level, in_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (out_valid || core_req) bad = 1'b1;
      end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_output: activity=%b want 0", bad); end
   endtask

   // Random modes, data and handshake pressure against the stream model.
   task automatic test_random_streams();
      for (int it = 0; it < 8; it++) begin
         int mode;
         bit dec;
         logic [BLK_W-1:0] iv_r;
         int n;
         int sent = 0;
         int got  = 0;
         bit bad_dec = 1'b0;
         bit bad_lvl = 1'b0;
         mode = $urandom_range(0, 2);
         dec  = 1'($urandom_range(0, 1));
         iv_r = rand_blk();
         if (mode == 2 && $urandom_range(0, 1) == 1) iv_r[CTR_W-1:0] = 32'hFFFF_FFFE;
         n = $urandom_range(3, 10);
         blk_q.delete();
         for (int k = 0; k < n; k++) blk_q.push_back(rand_blk());
         model_expected(mode, dec, iv_r);
         wait_idle();
         load_cfg(2'(mode), dec, iv_r);
         for (int c = 0; c < 400 && got < n; c++) begin
            @(negedge clk);
            in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            in_data   = (sent < n) ? blk_q[sent] : '0;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (core_req && core_dec !== ((mode == 2) ? 1'b0 : dec)) bad_dec = 1'b1;
            if (fifo_level > 3'(FIFO_DEPTH)) bad_lvl = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
               n_checks++;
               if (out_data !== exp_q[got]) begin n_fail++; $display("FAIL rand_it%0d_blk%0d mode=%0d dec=%0d: got %h want %h", it, got, mode, dec, out_data, exp_q[got]); end
               got++;
            end
         end
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b0;
         n_checks++; if (got != n)    begin n_fail++; $display("FAIL rand_it%0d_count: got %0d outputs want %0d", it, got, n); end
         n_checks++; if (bad_dec)     begin n_fail++; $display("FAIL rand_it%0d_core_dec: wrong direction seen, mode=%0d dec=%0d", it, mode, dec); end
         n_checks++; if (bad_lvl)     begin n_fail++; $display("FAIL rand_it%0d_level: level exceeded %0d", it, FIFO_DEPTH); end
      end
   endtask

   initial begin
      test_reset();
      test_ecb_latency();
      test_cbc_enc();
      test_ctr_wrap();
      test_backpressure();
      test_clear_in_wait();
      test_err();
      test_reset_mid();
      test_random_streams();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
